// File: rtl/cgra_pwr_seq_if.sv
// Control/status bundle between the always-on register block (master) and the
// CGRA power-domain sequencer (slave).
interface cgra_pwr_seq_if;
  logic       off_req_i;
  logic       on_req_i;
  logic       cgra_busy_i;
  logic       pwr_sw_ack_i;
  logic       pwr_sw_on_o;
  logic       clk_en_o;
  logic       iso_o;
  logic       cgra_rst_no;
  logic [3:0] state_o;
  logic       done_o;
  logic       err_o;

  modport master (
    output off_req_i, on_req_i, cgra_busy_i, pwr_sw_ack_i,
    input  pwr_sw_on_o, clk_en_o, iso_o, cgra_rst_no, state_o, done_o, err_o
  );

  modport slave (
    input  off_req_i, on_req_i, cgra_busy_i, pwr_sw_ack_i,
    output pwr_sw_on_o, clk_en_o, iso_o, cgra_rst_no, state_o, done_o, err_o
  );
endinterface

// File: rtl/cgra_pwr_seq.sv
// Power-domain sequencer for the CGRA: orders clock gate, isolation, reset and
// power switch on power-off/power-on commands, with drain wait and ack timeout.
module cgra_pwr_seq #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned ACK_TIMEOUT   = 1023
) (
  input logic            clk_i,
  input logic            rst_ni,
  cgra_pwr_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    ST_ON       = 4'd0,
    ST_DRAIN    = 4'd1,
    ST_CLK_OFF  = 4'd2,
    ST_ISO      = 4'd3,
    ST_SW_OFF   = 4'd4,
    ST_OFF      = 4'd5,
    ST_SW_ON    = 4'd6,
    ST_RST_HOLD = 4'd7,
    ST_ISO_REL  = 4'd8
  } state_e;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  RST_LAST    = 8'(RST_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        sw_on_q, sw_on_d;
  logic        clk_en_q, clk_en_d;
  logic        iso_q, iso_d;
  logic        rst_n_q, rst_n_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      ST_ON: begin
        if (bus.off_req_i && !bus.on_req_i) begin
          state_d = ST_DRAIN;
          err_d   = 1'b0;
        end
      end
      ST_DRAIN: begin
        // A cancel wins even if the CGRA has just gone idle.
        if (bus.on_req_i)         state_d = ST_ON;
        else if (!bus.cgra_busy_i) state_d = ST_CLK_OFF;
      end
      ST_CLK_OFF: begin
        if (wait_cnt_q == SETTLE_LAST) state_d = ST_ISO;
      end
      ST_ISO: begin
        if (wait_cnt_q == SETTLE_LAST) state_d = ST_SW_OFF;
      end
      ST_SW_OFF: begin
        if (!bus.pwr_sw_ack_i) begin
          state_d = ST_OFF;
          done_d  = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_OFF;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_OFF: begin
        if (bus.on_req_i && !bus.off_req_i) begin
          state_d = ST_SW_ON;
          err_d   = 1'b0;
        end
      end
      ST_SW_ON: begin
        // On timeout the domain falls back to OFF with the switch reopened.
        if (bus.pwr_sw_ack_i) begin
          state_d = ST_RST_HOLD;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_OFF;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_RST_HOLD: begin
        if (wait_cnt_q == RST_LAST) state_d = ST_ISO_REL;
      end
      ST_ISO_REL: begin
        state_d = ST_ON;
        done_d  = 1'b1;
      end
      default: state_d = ST_ON;
    endcase

    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
      tmo_cnt_d  = 16'd0;
    end else begin
      wait_cnt_d = sat_inc8(wait_cnt_q);
      tmo_cnt_d  = sat_inc16(tmo_cnt_q);
    end

    // Outputs follow the state being entered so they register on the same edge.
    case (state_d)
      ST_ON, ST_DRAIN: {sw_on_d, clk_en_d, iso_d, rst_n_d} = 4'b1101;
      ST_CLK_OFF:      {sw_on_d, clk_en_d, iso_d, rst_n_d} = 4'b1001;
      ST_ISO:          {sw_on_d, clk_en_d, iso_d, rst_n_d} = 4'b1010;
      ST_SW_OFF:       {sw_on_d, clk_en_d, iso_d, rst_n_d} = 4'b0010;
      ST_OFF:          {sw_on_d, clk_en_d, iso_d, rst_n_d} = 4'b0010;
      ST_SW_ON:        {sw_on_d, clk_en_d, iso_d, rst_n_d} = 4'b1010;
      ST_RST_HOLD:     {sw_on_d, clk_en_d, iso_d, rst_n_d} = 4'b1110;
      ST_ISO_REL:      {sw_on_d, clk_en_d, iso_d, rst_n_d} = 4'b1100;
      default:         {sw_on_d, clk_en_d, iso_d, rst_n_d} = 4'b1101;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_ON;
      wait_cnt_q <= 8'd0;
      tmo_cnt_q  <= 16'd0;
      sw_on_q    <= 1'b1;
      clk_en_q   <= 1'b1;
      iso_q      <= 1'b0;
      rst_n_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      sw_on_q    <= sw_on_d;
      clk_en_q   <= clk_en_d;
      iso_q      <= iso_d;
      rst_n_q    <= rst_n_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.pwr_sw_on_o = sw_on_q;
  assign bus.clk_en_o    = clk_en_q;
  assign bus.iso_o       = iso_q;
  assign bus.cgra_rst_no = rst_n_q;
  assign bus.state_o     = state_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_cgra_pwr_seq.sv
// Scoreboard bench for cgra_pwr_seq: sequence tasks compute the expected per-edge
// timeline from the sequencing rules; a monitor compares every edge and done pulse.
module tb_cgra_pwr_seq;
  localparam int S  = 4;
  localparam int RC = 8;
  localparam int T  = 16;
  localparam int ON = 0, DRAIN = 1, CLK_OFF = 2, ISO = 3, SW_OFF = 4,
                 OFF = 5, SW_ON = 6, RST_HOLD = 7, ISO_REL = 8;

  typedef struct {
    int         e;
    logic [3:0] st;
    logic [5:0] v;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edge_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  int   ack_delay = 0;
  logic [31:0] sw_hist = '0;
  snap_t snap_q[$];
  int    done_q[$];
  snap_t cur;
  int    de;
  logic [9:0] act, expv;
  int   m_state = ON;
  bit   m_err = 1'b0;

  cgra_pwr_seq_if bus();

  cgra_pwr_seq #(.SETTLE_CYCLES(S), .RST_CYCLES(RC), .ACK_TIMEOUT(T)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Power switch model: acknowledge follows the switch control after ack_delay cycles.
  always @(posedge clk) sw_hist <= {sw_hist[30:0], bus.pwr_sw_on_o};
  assign bus.pwr_sw_ack_i = (ack_delay == 0) ? bus.pwr_sw_on_o : sw_hist[5'(ack_delay - 1)];

  function automatic logic [3:0] outs(input int st);
    case (st)
      ON, DRAIN:   return 4'b1101;
      CLK_OFF:     return 4'b1001;
      ISO, SW_ON:  return 4'b1010;
      SW_OFF, OFF: return 4'b0010;
      RST_HOLD:    return 4'b1110;
      ISO_REL:     return 4'b1100;
      default:     return 4'b0000;
    endcase
  endfunction

  task automatic exp_span(input int first, input int last, input int st,
                          input bit err, input bit done_first, input bit rst_low);
    snap_t x;
    logic [3:0] o;
    for (int e = first; e <= last; e++) begin
      o = outs(st);
      if (rst_low) o[0] = 1'b0;
      x.e  = e;
      x.st = 4'(st);
      x.v  = {o, (done_first && e == first), err};
      snap_q.push_back(x);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.on_req_i  = 1'($urandom_range(0, 1));
    bus.off_req_i = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_req();
    bus.on_req_i  = 1'b0;
    bus.off_req_i = 1'b0;
  endtask

  // Stay in ON or OFF, throwing in commands that must be ignored there.
  task automatic idle(input int n);
    int r;
    exp_span(edge_cnt + 1, edge_cnt + n, m_state, m_err, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 2);
      clear_req();
      if (r == 1) begin
        if (m_state == ON) bus.on_req_i = 1'b1;
        else               bus.off_req_i = 1'b1;
      end else if (r == 2) begin
        bus.on_req_i  = 1'b1;
        bus.off_req_i = 1'b1;
      end
      step();
    end
    clear_req();
  endtask

  task automatic pwr_off(input int b, input int d);
    int s, c, w, f, x;
    bit to;
    ack_delay = d;
    s  = edge_cnt + 1;
    c  = s + b + 1;
    w  = c + 2 * S;
    to = (d > T - 1);
    f  = to ? w + T : w + 1 + d;
    exp_span(s, c - 1, DRAIN, 1'b0, 1'b0, 1'b0);
    exp_span(c, c + S - 1, CLK_OFF, 1'b0, 1'b0, 1'b0);
    exp_span(c + S, w - 1, ISO, 1'b0, 1'b0, 1'b0);
    exp_span(w, f - 1, SW_OFF, 1'b0, 1'b0, 1'b0);
    exp_span(f, f, OFF, to, 1'b1, 1'b0);
    done_q.push_back(f);
    m_err = to;
    m_state = OFF;
    bus.off_req_i   = 1'b1;
    bus.cgra_busy_i = (b > 0);
    step();
    clear_req();
    repeat (b) step();
    bus.cgra_busy_i = 1'b0;
    while (edge_cnt < f) begin
      x = edge_cnt + 1;
      if (x >= c + 1) noise();
      step();
      clear_req();
    end
  endtask

  task automatic pwr_on(input int d);
    int s, r, f, x;
    ack_delay = d;
    s = edge_cnt + 1;
    if (d > T - 1) begin
      f = s + T;
      exp_span(s, f - 1, SW_ON, 1'b0, 1'b0, 1'b0);
      exp_span(f, f, OFF, 1'b1, 1'b1, 1'b0);
      m_err = 1'b1;
      m_state = OFF;
    end else begin
      r = s + 1 + d;
      f = r + RC + 1;
      exp_span(s, r - 1, SW_ON, 1'b0, 1'b0, 1'b0);
      exp_span(r, r + RC - 1, RST_HOLD, 1'b0, 1'b0, 1'b0);
      exp_span(r + RC, r + RC, ISO_REL, 1'b0, 1'b0, 1'b0);
      exp_span(f, f, ON, 1'b0, 1'b1, 1'b0);
      m_err = 1'b0;
      m_state = ON;
    end
    done_q.push_back(f);
    bus.on_req_i = 1'b1;
    step();
    clear_req();
    while (edge_cnt < f) begin
      x = edge_cnt + 1;
      if (x >= s + 1) noise();
      step();
      clear_req();
    end
  endtask

  task automatic cancel(input int k, input bit bz);
    int s;
    s = edge_cnt + 1;
    exp_span(s, s + k - 1, DRAIN, 1'b0, 1'b0, 1'b0);
    exp_span(s + k, s + k, ON, 1'b0, 1'b0, 1'b0);
    m_err = 1'b0;
    m_state = ON;
    bus.off_req_i   = 1'b1;
    bus.cgra_busy_i = bz;
    step();
    bus.off_req_i = 1'b0;
    repeat (k - 1) step();
    bus.on_req_i = 1'b1;
    step();
    bus.on_req_i    = 1'b0;
    bus.cgra_busy_i = 1'b0;
  endtask

  task automatic reset_in_iso();
    int s, c, rr;
    ack_delay = 0;
    s  = edge_cnt + 1;
    c  = s + 1;
    rr = c + S + 2;
    exp_span(s, s, DRAIN, 1'b0, 1'b0, 1'b0);
    exp_span(c, c + S - 1, CLK_OFF, 1'b0, 1'b0, 1'b0);
    exp_span(c + S, rr - 1, ISO, 1'b0, 1'b0, 1'b0);
    exp_span(rr, rr, ON, 1'b0, 1'b0, 1'b1);
    m_err = 1'b0;
    m_state = ON;
    bus.off_req_i   = 1'b1;
    bus.cgra_busy_i = 1'b0;
    step();
    bus.off_req_i = 1'b0;
    while (edge_cnt < rr - 1) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: per-edge snapshot compare plus done-pulse scoreboard.
  always @(negedge clk) begin
    while (snap_q.size() > 0 && snap_q[0].e < edge_cnt) begin
      cur = snap_q.pop_front();
      checks++;
      failures++;
      $display("FAIL stale_expect edge=%0d expected_at=%0d", edge_cnt, cur.e);
    end
    if (snap_q.size() > 0 && snap_q[0].e == edge_cnt) begin
      cur  = snap_q.pop_front();
      act  = {bus.state_o, bus.pwr_sw_on_o, bus.clk_en_o, bus.iso_o,
              bus.cgra_rst_no, bus.done_o, bus.err_o};
      expv = {cur.st, cur.v};
      checks++;
      if (act !== expv) begin
        failures++;
        $display("FAIL snapshot edge=%0d actual{st,sw,clk,iso,rstn,done,err}=%b required=%b",
                 edge_cnt, act, expv);
      end
    end
    if (bus.done_o === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_done edge=%0d actual=1 required=0", edge_cnt);
      end else begin
        de = done_q.pop_front();
        if (de != edge_cnt) begin
          failures++;
          $display("FAIL done_edge actual=%0d required=%0d", edge_cnt, de);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog edge=%0d actual=running required=finished", edge_cnt);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bus.off_req_i   = 1'b0;
    bus.on_req_i    = 1'b0;
    bus.cgra_busy_i = 1'b0;
    rst_n = 1'b0;
    exp_span(1, 2, ON, 1'b0, 1'b0, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    idle(5);

    pwr_off(0, 0);
    idle(25);
    pwr_on(3);
    idle(25);
    pwr_off(20, 0);
    idle(25);
    pwr_on(0);
    idle(5);
    cancel(3, 1'b1);
    idle(3);
    cancel(1, 1'b0);
    idle(3);
    pwr_off(0, 20);
    idle(25);
    pwr_on(20);
    idle(25);
    pwr_on(2);
    idle(25);
    reset_in_iso();
    idle(5);

    for (int it = 0; it < 20; it++) begin
      if (m_state == ON) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 1) cancel($urandom_range(1, 5), 1'b1);
          else                           cancel(1, 1'b0);
          idle(3);
        end else begin
          pwr_off($urandom_range(0, 6), $urandom_range(0, 20));
          idle(25);
        end
      end else begin
        pwr_on($urandom_range(0, 20));
        idle(25);
      end
    end

    step();
    step();
    checks++;
    if (snap_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expect actual=%0d required=0", snap_q.size());
    end
    checks++;
    if (done_q.size() != 0) begin
      failures++;
      $display("FAIL missing_done actual=%0d required=0", done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
